// File: rtl/systolic_fpga_example_txn_tracker.sv
// systolic_fpga_example_txn_tracker: issues num_txn requests with a cap on in-flight
// transactions, retires one per completion and pulses done once fully drained.
module systolic_fpga_example_txn_tracker #(
    parameter int C_LEN_WIDTH       = 32,
    parameter int C_MAX_OUTSTANDING = 16,
    localparam int OW               = $clog2(C_MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [C_LEN_WIDTH-1:0] num_txn,
    output logic                   req_valid,
    input  logic                   req_ready,
    input  logic                   cpl_valid,
    output logic                   busy,
    output logic                   done,
    output logic [OW-1:0]          outstanding,
    output logic [C_LEN_WIDTH-1:0] issued_count,
    output logic                   cpl_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t                 state_q, state_d;
    logic [C_LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [C_LEN_WIDTH-1:0] issued_q, issued_d;
    logic [OW-1:0]          out_q, out_d;
    logic                   err_q, err_d;
    logic                   fire, cpl_acc, spurious, start_acc;
    // req_valid depends only on registered state, never on req_ready
    assign req_valid    = (state_q == ISSUE) && (out_q != OW'(C_MAX_OUTSTANDING));
    assign fire         = req_valid & req_ready;
    assign cpl_acc      = cpl_valid & ((out_q != '0) | fire);
    assign spurious     = cpl_valid & (out_q == '0) & ~fire;
    assign start_acc    = start & (state_q == IDLE);
    assign busy         = state_q != IDLE;
    assign done         = state_q == DONE;
    assign outstanding  = out_q;
    assign issued_count = issued_q;
    assign cpl_err      = err_q;
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        issued_d    = issued_q;
        out_d       = (fire & ~cpl_acc) ? out_q + 1'b1 : (cpl_acc & ~fire) ? out_q - 1'b1 : out_q;
        err_d       = (start_acc ? 1'b0 : err_q) | spurious;
        case (state_q)
            IDLE: if (start) begin
                state_d     = (num_txn != '0) ? ISSUE : DONE;
                remaining_d = num_txn;
                issued_d    = '0;
            end
            ISSUE: if (fire) begin
                remaining_d = remaining_q - 1'b1;
                issued_d    = issued_q + 1'b1;
                state_d     = (remaining_q == C_LEN_WIDTH'(1)) ? DRAIN : ISSUE;
            end
            DRAIN: state_d = (out_q == '0) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            issued_q    <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            issued_q    <= issued_d;
            out_q       <= out_d;
            err_q       <= err_d;
        end
    end
endmodule

// File: tb/tb_systolic_fpga_example_txn_tracker.sv
// tb_systolic_fpga_example_txn_tracker: directed checks on a MAX=16 and a MAX=2 instance.
module tb_systolic_fpga_example_txn_tracker;
    logic        clk = 0, rst_n = 0;
    logic        a_start = 0, a_ready = 0, a_cpl = 0, a_rv, a_busy, a_done, a_err;
    logic [31:0] a_num = 0, a_issued;
    logic [4:0]  a_out;
    logic        b_start = 0, b_ready = 0, b_cpl = 0, b_rv, b_busy, b_done, b_err;
    logic [31:0] b_num = 0, b_issued;
    logic [1:0]  b_out;
    int          n_cmp = 0, n_err = 0;
    always #5 clk = ~clk;
    systolic_fpga_example_txn_tracker #(.C_LEN_WIDTH(32), .C_MAX_OUTSTANDING(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .num_txn(a_num), .req_valid(a_rv),
        .req_ready(a_ready), .cpl_valid(a_cpl), .busy(a_busy), .done(a_done),
        .outstanding(a_out), .issued_count(a_issued), .cpl_err(a_err));
    systolic_fpga_example_txn_tracker #(.C_LEN_WIDTH(32), .C_MAX_OUTSTANDING(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .num_txn(b_num), .req_valid(b_rv),
        .req_ready(b_ready), .cpl_valid(b_cpl), .busy(b_busy), .done(b_done),
        .outstanding(b_out), .issued_count(b_issued), .cpl_err(b_err));
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        int exp_out[10] = '{1, 2, 3, 3, 2, 1, 0, 0, 0, 0};
        int dn;
        logic stuck;
        logic [31:0] iss;
        tick(); tick();
        chk("rst_busy", a_busy, 0); chk("rst_rv", a_rv, 0); chk("rst_out", a_out, 0);
        chk("rst_iss", a_issued, 0); chk("rst_err", a_err, 0); chk("rst_done", a_done, 0);
        rst_n = 1;
        // basic run: 4 txns, completions 3 cycles after each fire
        a_start = 1; a_num = 4; a_ready = 1;
        tick();
        a_start = 0;
        chk("basic_first_rv", a_rv, 1);
        for (int k = 1; k <= 10; k++) begin
            a_cpl = (k >= 4 && k <= 7);
            tick();
            chk($sformatf("basic_out%0d", k), a_out, exp_out[k-1]);
            chk($sformatf("basic_done%0d", k), a_done, k == 8);
        end
        a_cpl = 0;
        chk("basic_iss", a_issued, 4); chk("basic_busy", a_busy, 0);
        // simultaneous fire+completion, cap, ignored start
        a_ready = 0; a_start = 1; a_num = 20;
        tick();
        a_start = 0; a_ready = 1;
        tick(); tick();
        a_cpl = 1;
        tick();
        chk("sim2_out", a_out, 2); chk("sim2_iss", a_issued, 3);
        a_cpl = 0;
        repeat (13) tick();
        chk("pre15_out", a_out, 15);
        a_cpl = 1;
        tick();
        chk("sim15_out", a_out, 15); chk("sim15_rv", a_rv, 1); chk("sim15_iss", a_issued, 17);
        a_cpl = 0;
        tick();
        chk("cap16_out", a_out, 16); chk("cap16_rv", a_rv, 0);
        a_start = 1; a_num = 5;
        tick();
        a_start = 0;
        chk("ign_iss", a_issued, 18); chk("ign_busy", a_busy, 1);
        dn = 0; iss = 0;
        for (int i = 0; i < 60 && dn == 0; i++) begin
            a_cpl = (a_out != 0);
            tick();
            if (a_done) begin dn++; iss = a_issued; end
        end
        a_cpl = 0;
        chk("ign_done_seen", dn, 1); chk("ign_final_iss", iss, 20); chk("ign_err", a_err, 0);
        tick();
        chk("ign_idle", a_busy, 0);
        // zero-length command
        a_start = 1; a_num = 0;
        tick();
        a_start = 0;
        chk("zero_done", a_done, 1); chk("zero_rv", a_rv, 0); chk("zero_iss", a_issued, 0);
        tick();
        chk("zero_done_off", a_done, 0); chk("zero_busy", a_busy, 0);
        // spurious completion then short command with done latency
        a_cpl = 1;
        tick();
        a_cpl = 0;
        chk("spur_err", a_err, 1); chk("spur_out", a_out, 0);
        a_start = 1; a_num = 1;
        tick();
        a_start = 0;
        chk("spur_clr", a_err, 0); chk("one_rv", a_rv, 1);
        tick();
        chk("one_out", a_out, 1); chk("one_rv_off", a_rv, 0);
        a_cpl = 1;
        tick();
        a_cpl = 0;
        chk("one_out0", a_out, 0); chk("one_not_done", a_done, 0);
        tick();
        chk("one_done", a_done, 1);
        tick();
        chk("one_idle", a_busy, 0);
        // backpressure on MAX=2 instance
        b_start = 1; b_num = 5;
        tick();
        b_start = 0;
        stuck = 1;
        for (int i = 0; i < 10; i++) begin
            if (!b_rv) stuck = 0;
            tick();
        end
        chk("bp_rv_held", stuck, 1);
        b_ready = 1;
        tick(); tick();
        chk("bp_out2", b_out, 2); chk("bp_rv_cap", b_rv, 0);
        tick();
        chk("bp_iss2", b_issued, 2);
        b_cpl = 1;
        tick();
        b_cpl = 0;
        chk("bp_out1", b_out, 1); chk("bp_rv_again", b_rv, 1);
        tick();
        chk("bp_rv_cap2", b_rv, 0);
        tick();
        chk("bp_iss3", b_issued, 3);
        dn = 0; iss = 0;
        for (int i = 0; i < 60 && dn == 0; i++) begin
            b_cpl = (b_out != 0);
            tick();
            if (b_done) begin dn++; iss = b_issued; end
        end
        b_cpl = 0;
        chk("bp_done_seen", dn, 1); chk("bp_final_iss", iss, 5); chk("bp_err", b_err, 0);
        // async reset mid-ISSUE with 3 outstanding
        a_start = 1; a_num = 10;
        tick();
        a_start = 0;
        tick(); tick(); tick();
        chk("pre_rst_out", a_out, 3);
        #2 rst_n = 0;
        #1;
        chk("arst_rv", a_rv, 0); chk("arst_busy", a_busy, 0);
        chk("arst_out", a_out, 0); chk("arst_iss", a_issued, 0);
        tick(); tick();
        rst_n = 1;
        tick();
        chk("post_rst_busy", a_busy, 0); chk("post_rst_rv", a_rv, 0);
        a_cpl = 1;
        tick();
        a_cpl = 0;
        chk("post_rst_err", a_err, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
